fp16_add_rr_sched: RTL

//  Shares one combinational FP16 adder (new_fp16_add, 1-5-10) between NUM_REQ requesters.
//  Per-requester valid/ready request ports; round-robin arbitration; one registered result stage.

---
 rtl/fp16_add_rr_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fp16_add_rr_sched.sv
// Round-robin scheduler sharing one combinational FP16 adder between NUM_REQ requesters,
// with a single registered valid/ready result stage tagged by requester ID.

module new_fp16_add (
  input  logic [1:0][15:0] operands_i,
  output logic [15:0]      result_o
);
  logic [15:0] big, sml;
  logic [6:0]  e_big, e_sml, shamt, e_res;
  logic [13:0] m_big, m_sml, m_sml_sh;
  logic [14:0] sum;
  logic [11:0] rnd;
  logic        rbit, a_spec, b_spec, a_nan, b_nan;

  always_comb begin
    big = operands_i[1];
    sml = operands_i[0];
    if (operands_i[0][14:0] > operands_i[1][14:0]) begin
      big = operands_i[0];
      sml = operands_i[1];
    end
    e_big = (big[14:10] == 5'd0) ? 7'd1 : {2'b00, big[14:10]};
    e_sml = (sml[14:10] == 5'd0) ? 7'd1 : {2'b00, sml[14:10]};
    m_big = {|big[14:10], big[9:0], 3'b000};
    m_sml = {|sml[14:10], sml[9:0], 3'b000};
    shamt = e_big - e_sml;
    // Bits shifted out of the smaller operand collapse into a sticky LSB for rounding
    m_sml_sh = m_sml >> shamt;
    m_sml_sh[0] = m_sml_sh[0] | ((m_sml_sh << shamt) != m_sml);
    if (big[15] == sml[15]) sum = {1'b0, m_big} + {1'b0, m_sml_sh};
    else                    sum = {1'b0, m_big} - {1'b0, m_sml_sh};

    e_res = e_big;
    if (sum[14]) begin
      sum   = {1'b0, sum[14:2], sum[1] | sum[0]};
      e_res = e_res + 7'd1;
    end else begin
      for (int unsigned i = 0; i < 13; i++) begin
        if (!sum[13] && e_res > 7'd1) begin
          sum   = sum << 1;
          e_res = e_res - 7'd1;
        end
      end
    end

    rbit = sum[2] & (sum[1] | sum[0] | sum[3]);
    rnd  = {1'b0, sum[13:3]} + {11'd0, rbit};
    if (rnd[11]) begin
      rnd   = rnd >> 1;
      e_res = e_res + 7'd1;
    end

    a_spec = &operands_i[1][14:10];
    b_spec = &operands_i[0][14:10];
    a_nan  = a_spec & |operands_i[1][9:0];
    b_nan  = b_spec & |operands_i[0][9:0];

    if (a_nan || b_nan || (a_spec && b_spec && operands_i[1][15] != operands_i[0][15]))
      result_o = 16'h7E00;
    else if (a_spec || b_spec)
      result_o = {big[15], 5'h1F, 10'h000};
    else if (sum == 15'd0)
      result_o = {big[15] & sml[15], 15'd0};
    else if (e_res >= 7'd31)
      result_o = {big[15], 5'h1F, 10'h000};
    else
      result_o = {big[15], rnd[10] ? e_res[4:0] : 5'd0, rnd[9:0]};
  end
endmodule

module fp16_add_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0][15:0] req_a_i,
  input  logic [NUM_REQ-1:0][15:0] req_b_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [15:0]              resp_data_o,
  output logic [ID_W-1:0]          resp_id_o,
  output logic [31:0]              busy_cnt_o
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]      state;
  logic [ID_W-1:0] rr_ptr, gnt_id, ptr_next;
  logic            gnt_any, can_accept;
  int unsigned     idx;
  logic [1:0][15:0] add_ops;
  logic [15:0]     sum;

  assign resp_valid_o = (state == FULL);
  assign can_accept   = ~resp_valid_o | resp_ready_i;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
      idx = (unsigned'(int'(rr_ptr)) + k) % unsigned'(NUM_REQ);
      if (!gnt_any && can_accept && !rst_i && req_valid_i[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
    req_ready_o = '0;
    if (gnt_any) req_ready_o[gnt_id] = 1'b1;
  end

  assign ptr_next   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
  assign add_ops[1] = req_a_i[gnt_id];
  assign add_ops[0] = req_b_i[gnt_id];

  new_fp16_add u_add (
    .operands_i (add_ops),
    .result_o   (sum)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      resp_data_o <= '0;
      resp_id_o   <= '0;
      rr_ptr      <= '0;
      busy_cnt_o  <= '0;
    end else begin
      if (gnt_any) begin
        state       <= FULL;
        resp_data_o <= sum;
        resp_id_o   <= gnt_id;
        rr_ptr      <= ptr_next;
      end else if (resp_ready_i) begin
        state <= EMPTY;
      end
      if (resp_valid_o && !resp_ready_i && busy_cnt_o != '1)
        busy_cnt_o <= busy_cnt_o + 32'd1;
    end
  end
endmodule
